i2c_scl_gen: RTL and testbench
==============================

Name: i2c_scl_gen

Overview:
Parametrised I2C master SCL generator with a runtime-programmable half-period, replacing the fixed 1/2/3 MHz divider.
Adds slave clock-stretch detection with timeout, repeated-START support, a bus-free hold after STOP, and bit/strobe outputs for the SDA engine.
Drives SCL open-drain through an output-enable; the tristate lives at top level.

Parameters:
CNT_W, 8, width of half-period and phase counter
STRETCH_W, 16, width of stretch timeout counter
STRETCH_TO, 16'd1000, clk cycles of SCL held low by slave before timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
enable  in  1  block enable; deassertion while busy acts as a STOP request
half_period  in  CNT_W  clk cycles per SCL half-phase; latched on START, values 0/1 clamped to 2
start_cond  in  1  START / repeated-START request pulse from SDA block
stop_cond  in  1  STOP request pulse from SDA block
stretch_en  in  1  1 = honour slave clock stretching
scl_in  in  1  sensed SCL line (asynchronous)
scl_oe  out  1  1 = pull SCL low, 0 = release
scl_rise  out  1  1-cycle pulse on SCL release into HIGH phase
scl_fall  out  1  1-cycle pulse on entering LOW phase
sample  out  1  1-cycle pulse at mid HIGH phase (cnt == hp_q>>1)
bit_cnt  out  4  SCL falls since START, 0..8, wraps 8->0
busy  out  1  high from accepted START until return to IDLE
stretching  out  1  high while slave holds SCL low in RISE_WAIT
timeout  out  1  sticky; set on stretch timeout, cleared on next accepted START
done  out  1  1-cycle pulse on STOP completion

Behaviour:
- Reset is sampled at posedge clk only. When reset==0: state IDLE, cnt 0, st_cnt 0, scl_oe 0, all pulses 0, bit_cnt 0, busy 0, stretching 0, timeout 0, synchroniser flops 1. Reset mid-transfer releases SCL the next cycle.
- scl_in passes through a 2-flop synchroniser (scl_s) before use.
- Pending flags stop_p and rs_p:
  - stop_p is set by stop_cond, or by enable==0 while busy.
  - rs_p is set by start_cond while busy.
  - Both clear when consumed at the end of HIGH.
- States:
  - IDLE: scl_oe 0. On start_cond & enable: latch hp_q, cnt 0, bit_cnt 0, clear timeout, busy 1, go to START_HOLD.
  - START_HOLD: scl_oe 0 for hp_q cycles. At cnt==hp_q-1: go to LOW, scl_oe 1, pulse scl_fall, cnt 0.
  - LOW: scl_oe 1. At cnt==hp_q-1: scl_oe 0, cnt 0. If stretch_en: go to RISE_WAIT, st_cnt 0. Else: go to HIGH, pulse scl_rise.
  - RISE_WAIT: scl_oe 0.
    - If scl_s==1: go to HIGH, pulse scl_rise, cnt 0.
    - Else: stretching 1, st_cnt++.
    - At st_cnt==STRETCH_TO-1: set timeout, go to IDLE, busy 0, no done pulse.
  - HIGH: scl_oe 0. Pulse sample at cnt==hp_q>>1. At cnt==hp_q-1:
    - stop_p set: go to STOP, cnt 0 (stop has priority over rs_p).
    - Else rs_p set: go to START_HOLD, bit_cnt 0, cnt 0.
    - Else: go to LOW, scl_oe 1, pulse scl_fall, bit_cnt = (bit_cnt==8) ? 0 : bit_cnt+1.
  - STOP: scl_oe 0 for hp_q cycles (bus-free time). At the end: pulse done, busy 0, go to IDLE.
- Period with stretch_en=0 is exactly 2*hp_q clk cycles.
- With stretch_en=1 and no slave stretching, RISE_WAIT adds 3 cycles: 2 synchroniser cycles plus the registered decision.
- start_cond in IDLE with enable==0 is ignored. stop_cond in IDLE is ignored.
- A half_period change while busy has no effect until the next START.
- All outputs are registered.

Test Plan:
1. reset=0 for 2 cycles, then half_period=5, stretch_en=0, start_cond pulse -> scl_oe 0 for 5 cycles, then square wave of 5 low / 5 high (100 kHz at 1 MHz clk); busy=1; scl_fall, scl_rise and sample each one pulse per period; sample occurs 2 cycles into HIGH.
2. After 9 SCL falls -> bit_cnt sequence 1..8 then 0. stop_cond mid LOW -> STOP taken at end of next HIGH; SCL held released 5 cycles; done pulse; busy 0.
3. start_cond while busy -> at end of HIGH, SCL stays released an extra 5 cycles (START_HOLD), bit_cnt=0, then LOW. start_cond and stop_cond both pending -> STOP wins.
4. stretch_en=1, scl_in tied to ~scl_oe -> HIGH entered 3 cycles after release. scl_in forced 0 for 50 cycles -> stretching=1 for those cycles; HIGH starts 3 cycles after scl_in rises; timeout stays 0.
5. stretch_en=1, scl_in stuck 0, STRETCH_TO=1000 -> after 1000 cycles in RISE_WAIT: timeout=1, busy=0, scl_oe=0, no done pulse. Next start_cond clears timeout.
6. half_period=1 -> behaves as 2 (4-cycle period). reset=0 asserted mid LOW -> next cycle scl_oe=0, state IDLE, bit_cnt=0.

Source files
------------

// File: rtl/i2c_scl_gen_if.sv
// Request/status bundle between the SDA engine (master) and the SCL generator (slave).
// scl_in carries the sensed bus line; scl_oe is the open-drain pull-down enable.
interface i2c_scl_gen_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [CNT_W-1:0] half_period;
    logic             start_cond;
    logic             stop_cond;
    logic             stretch_en;
    logic             scl_in;
    logic             scl_oe;
    logic             scl_rise;
    logic             scl_fall;
    logic             sample;
    logic [3:0]       bit_cnt;
    logic             busy;
    logic             stretching;
    logic             timeout;
    logic             done;

    modport master (
        output enable, half_period, start_cond, stop_cond, stretch_en, scl_in,
        input  scl_oe, scl_rise, scl_fall, sample, bit_cnt, busy, stretching, timeout, done
    );

    modport slave (
        input  enable, half_period, start_cond, stop_cond, stretch_en, scl_in,
        output scl_oe, scl_rise, scl_fall, sample, bit_cnt, busy, stretching, timeout, done
    );
endinterface

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: programmable half-period, clock stretching with timeout, repeated START, STOP bus-free hold.
// All outputs registered (1-cycle latency from decision); start/stop requests while busy are held pending until end of HIGH.
module i2c_scl_gen #(
    parameter int                    CNT_W      = 8,
    parameter int                    STRETCH_W  = 16,
    parameter logic [STRETCH_W-1:0]  STRETCH_TO = 16'd1000
) (
    input  logic         clk,
    input  logic         reset,
    i2c_scl_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_HOLD,
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     hp_q, hp_d;
    logic [STRETCH_W-1:0] st_cnt_q, st_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 scl_oe_q, scl_oe_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 sample_q, sample_d;
    logic                 busy_q, busy_d;
    logic                 stretching_q, stretching_d;
    logic                 timeout_q, timeout_d;
    logic                 done_q, done_d;
    logic                 stop_p_q, stop_p_d;
    logic                 rs_p_q, rs_p_d;
    logic [1:0]           sync_q;

    logic                 scl_s;
    logic [CNT_W-1:0]     hp_in;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 cnt_last;
    logic                 stop_pend;
    logic                 rs_pend;

    assign scl_s    = sync_q[1];
    // Half-periods below 2 would leave no room for the mid-HIGH sample point.
    assign hp_in    = (bus.half_period < CNT_W'(2)) ? CNT_W'(2) : bus.half_period;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cnt_last = (cnt_q == hp_q - CNT_W'(1));

    assign stop_pend = stop_p_q | (busy_q & (bus.stop_cond | ~bus.enable));
    assign rs_pend   = rs_p_q   | (busy_q & bus.start_cond);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hp_d         = hp_q;
        st_cnt_d     = st_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        scl_oe_d     = scl_oe_q;
        busy_d       = busy_q;
        timeout_d    = timeout_q;
        stop_p_d     = stop_pend;
        rs_p_d       = rs_pend;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        sample_d     = 1'b0;
        stretching_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                scl_oe_d = 1'b0;
                busy_d   = 1'b0;
                stop_p_d = 1'b0;
                rs_p_d   = 1'b0;
                cnt_d    = '0;
                st_cnt_d = '0;
                if (bus.start_cond && bus.enable) begin
                    hp_d      = hp_in;
                    bit_cnt_d = 4'd0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START_HOLD;
                end
            end

            S_START_HOLD: begin
                scl_oe_d = 1'b0;
                if (cnt_last) begin
                    state_d  = S_LOW;
                    scl_oe_d = 1'b1;
                    fall_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_LOW: begin
                scl_oe_d = 1'b1;
                if (cnt_last) begin
                    scl_oe_d = 1'b0;
                    cnt_d    = '0;
                    if (bus.stretch_en) begin
                        state_d  = S_RISE_WAIT;
                        st_cnt_d = '0;
                    end else begin
                        state_d = S_HIGH;
                        rise_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_RISE_WAIT: begin
                scl_oe_d = 1'b0;
                if (scl_s) begin
                    state_d = S_HIGH;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else if (st_cnt_q == STRETCH_TO - STRETCH_W'(1)) begin
                    // Slave never let go: abandon the transfer without a STOP.
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    stretching_d = 1'b1;
                    st_cnt_d     = st_cnt_q + STRETCH_W'(1);
                end
            end

            S_HIGH: begin
                scl_oe_d = 1'b0;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (stop_pend) begin
                        state_d  = S_STOP;
                        stop_p_d = 1'b0;
                        rs_p_d   = 1'b0;
                    end else if (rs_pend) begin
                        state_d   = S_START_HOLD;
                        bit_cnt_d = 4'd0;
                        rs_p_d    = 1'b0;
                    end else begin
                        state_d   = S_LOW;
                        scl_oe_d  = 1'b1;
                        fall_d    = 1'b1;
                        bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd0 : bit_cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d    = cnt_inc;
                    sample_d = (cnt_inc == (hp_q >> 1));
                end
            end

            S_STOP: begin
                scl_oe_d = 1'b0;
                if (cnt_last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d  = S_IDLE;
                scl_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hp_q         <= CNT_W'(2);
            st_cnt_q     <= '0;
            bit_cnt_q    <= 4'd0;
            scl_oe_q     <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            sample_q     <= 1'b0;
            busy_q       <= 1'b0;
            stretching_q <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            stop_p_q     <= 1'b0;
            rs_p_q       <= 1'b0;
            sync_q       <= 2'b11;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hp_q         <= hp_d;
            st_cnt_q     <= st_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            scl_oe_q     <= scl_oe_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            sample_q     <= sample_d;
            busy_q       <= busy_d;
            stretching_q <= stretching_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            stop_p_q     <= stop_p_d;
            rs_p_q       <= rs_p_d;
            sync_q       <= {sync_q[0], bus.scl_in};
        end
    end

    assign bus.scl_oe     = scl_oe_q;
    assign bus.scl_rise   = rise_q;
    assign bus.scl_fall   = fall_q;
    assign bus.sample     = sample_q;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.stretching = stretching_q;
    assign bus.timeout    = timeout_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: records one observation per clock and compares windows against hand-derived patterns.
module tb_i2c_scl_gen;

    localparam int F_OE   = 0;
    localparam int F_FALL = 1;
    localparam int F_RISE = 2;
    localparam int F_SMP  = 3;
    localparam int F_BUSY = 4;
    localparam int F_DONE = 5;
    localparam int F_STR  = 6;
    localparam int F_TMO  = 7;
    localparam int TR_N   = 1100;

    typedef struct packed {
        logic       oe;
        logic       fall;
        logic       rise;
        logic       smp;
        logic       busy;
        logic       done;
        logic       strch;
        logic       tmo;
        logic [3:0] bc;
    } obs_t;

    logic clk;
    logic reset;
    logic scl_hold;
    int   n_chk;
    int   n_fail;
    int   k;
    obs_t tr [0:TR_N-1];

    i2c_scl_gen_if #(.CNT_W(8)) bus ();

    i2c_scl_gen #(
        .CNT_W      (8),
        .STRETCH_W  (16),
        .STRETCH_TO (16'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Open-drain line: low when the master pulls or the slave holds it.
    assign bus.scl_in = ~bus.scl_oe & ~scl_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (k < TR_N) begin
            tr[k].oe    = bus.scl_oe;
            tr[k].fall  = bus.scl_fall;
            tr[k].rise  = bus.scl_rise;
            tr[k].smp   = bus.sample;
            tr[k].busy  = bus.busy;
            tr[k].done  = bus.done;
            tr[k].strch = bus.stretching;
            tr[k].tmo   = bus.timeout;
            tr[k].bc    = bus.bit_cnt;
        end
        k++;
    endtask

    function automatic logic [63:0] win(input int sel, input int s, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            case (sel)
                F_OE:    v[i] = tr[s+i].oe;
                F_FALL:  v[i] = tr[s+i].fall;
                F_RISE:  v[i] = tr[s+i].rise;
                F_SMP:   v[i] = tr[s+i].smp;
                F_BUSY:  v[i] = tr[s+i].busy;
                F_DONE:  v[i] = tr[s+i].done;
                F_STR:   v[i] = tr[s+i].strch;
                default: v[i] = tr[s+i].tmo;
            endcase
        end
        return v;
    endfunction

    initial begin
        n_chk            = 0;
        n_fail           = 0;
        k                = 0;
        reset            = 1'b0;
        scl_hold         = 1'b0;
        bus.enable       = 1'b0;
        bus.half_period  = 8'd5;
        bus.start_cond   = 1'b0;
        bus.stop_cond    = 1'b0;
        bus.stretch_en   = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_oe",     64'(tr[1].oe),   64'd0);
        chk("reset_busy",   64'(tr[1].busy), 64'd0);
        chk("reset_bitcnt", 64'(tr[1].bc),   64'd0);
        chk("reset_tmo",    64'(tr[1].tmo),  64'd0);
        chk("reset_pulses", 64'({tr[1].fall, tr[1].rise, tr[1].smp, tr[1].done, tr[1].strch}), 64'd0);

        // START with enable low is ignored
        reset          = 1'b1;
        bus.start_cond = 1'b1;
        step();
        bus.start_cond = 1'b0;
        step();
        chk("start_no_enable_busy", 64'({tr[2].busy, tr[3].busy}), 64'd0);

        // Test 1/2: hp=5 square wave, half_period change ignored, bit count, STOP
        bus.enable = 1'b1;
        k = 0;
        for (int i = 0; i < 115; i++) begin
            bus.start_cond = (i == 0);
            bus.stop_cond  = (i == 98);
            if (i == 1) bus.half_period = 8'd9;
            step();
        end
        bus.stop_cond = 1'b0;
        chk("t1_oe",     win(F_OE, 0, 25),   (64'h1F << 5) | (64'h1F << 15));
        chk("t1_fall",   win(F_FALL, 0, 25), (64'd1 << 5) | (64'd1 << 15));
        chk("t1_rise",   win(F_RISE, 0, 25), (64'd1 << 10) | (64'd1 << 20));
        chk("t1_sample", win(F_SMP, 0, 25),  (64'd1 << 12) | (64'd1 << 22));
        chk("t1_busy",   win(F_BUSY, 0, 25), (64'd1 << 25) - 64'd1);
        for (int i = 1; i <= 9; i++) begin
            chk("t2_bitcnt", 64'(tr[5 + 10*i].bc), 64'(i % 9));
        end
        chk("t2_stop_oe",   win(F_OE, 95, 20),   64'h1F);
        chk("t2_stop_rise", win(F_RISE, 96, 19), 64'd1 << 4);
        chk("t2_stop_fall", win(F_FALL, 96, 19), 64'd0);
        chk("t2_done",      win(F_DONE, 100, 15), 64'd1 << 10);
        chk("t2_busy_edge", 64'({tr[109].busy, tr[110].busy}), 64'b10);

        // STOP in IDLE is ignored
        bus.stop_cond = 1'b1;
        step();
        bus.stop_cond = 1'b0;
        step();
        chk("stop_idle", 64'({tr[115].busy, tr[116].busy, tr[116].oe, tr[116].done}), 64'd0);

        // Test 3: repeated START, then START+STOP together (STOP wins)
        bus.half_period = 8'd5;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            bus.start_cond = (i == 0) || (i == 27) || (i == 42);
            bus.stop_cond  = (i == 42);
            step();
        end
        bus.start_cond = 1'b0;
        bus.stop_cond  = 1'b0;
        chk("t3_bc_before_rs", 64'(tr[34].bc), 64'd2);
        chk("t3_bc_after_rs",  64'(tr[35].bc), 64'd0);
        chk("t3_rs_oe",        win(F_OE, 30, 15),   64'h1F << 10);
        chk("t3_rs_fall",      win(F_FALL, 30, 15), 64'd1 << 10);
        chk("t3_stopwins_oe",  win(F_OE, 45, 15),   64'd0);
        chk("t3_stopwins_done", win(F_DONE, 45, 15), 64'd1 << 10);
        chk("t3_busy_edge",    64'({tr[54].busy, tr[55].busy}), 64'b10);

        // Test 4: stretch enabled, first rise unstretched, second held 50 cycles
        bus.stretch_en = 1'b1;
        k = 0;
        for (int i = 0; i < 90; i++) begin
            bus.start_cond = (i == 0);
            bus.stop_cond  = (i == 77);
            if (i == 21) scl_hold = 1'b1;
            if (i == 73) scl_hold = 1'b0;
            step();
        end
        bus.start_cond = 1'b0;
        bus.stop_cond  = 1'b0;
        chk("t4_rw_oe",      win(F_OE, 8, 12),   64'hC03);
        chk("t4_rw_rise",    win(F_RISE, 8, 10), 64'd1 << 5);
        chk("t4_rw_sample",  win(F_SMP, 13, 5),  64'd1 << 2);
        chk("t4_str_first",  64'(tr[23].strch), 64'd0);
        chk("t4_stretching", win(F_STR, 24, 51), (64'd1 << 51) - 64'd1);
        chk("t4_str_end",    64'(tr[75].strch), 64'd0);
        chk("t4_str_oe",     win(F_OE, 23, 57), 64'd0);
        chk("t4_str_rise",   win(F_RISE, 70, 10), 64'd1 << 5);
        chk("t4_str_tmo",    win(F_TMO, 0, 90), 64'd0);
        chk("t4_done",       64'(tr[85].done), 64'd1);

        // Test 5: SCL stuck low -> timeout after 1000 cycles in RISE_WAIT
        scl_hold = 1'b1;
        k = 0;
        for (int i = 0; i < 1025; i++) begin
            bus.start_cond = (i == 0);
            step();
        end
        bus.start_cond = 1'b0;
        chk("t5_pre_tmo",    64'({tr[1009].tmo, tr[1009].busy, tr[1009].strch}), 64'b011);
        chk("t5_tmo_set",    64'({tr[1010].tmo, tr[1010].busy, tr[1010].oe, tr[1010].strch}), 64'b1000);
        chk("t5_no_done",    win(F_DONE, 1000, 25), 64'd0);
        chk("t5_tmo_sticky", 64'(tr[1024].tmo), 64'd1);

        // Test 6: half_period=1 clamps to 2; new START clears timeout; reset mid LOW
        scl_hold        = 1'b0;
        bus.stretch_en  = 1'b0;
        bus.half_period = 8'd1;
        k = 0;
        for (int i = 0; i < 11; i++) begin
            bus.start_cond = (i == 0);
            step();
        end
        bus.start_cond = 1'b0;
        chk("t6_tmo_clr", 64'({tr[0].tmo, tr[0].busy}), 64'b01);
        chk("t6_oe",      win(F_OE, 0, 11),   64'h4CC);
        chk("t6_fall",    win(F_FALL, 0, 11), 64'h444);
        chk("t6_rise",    win(F_RISE, 0, 11), 64'h110);
        chk("t6_sample",  win(F_SMP, 0, 11),  64'h220);
        chk("t6_bc",      64'(tr[10].bc), 64'd2);
        reset = 1'b0;
        step();
        chk("t6_reset_mid", 64'({tr[11].oe, tr[11].busy, tr[11].bc}), 64'd0);
        reset = 1'b1;
        step();
        chk("t6_after_reset", 64'({tr[12].oe, tr[12].busy, tr[12].fall}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
